// File: rtl/itch_msg_parser_wide.sv
// Beat-wide ITCH order-message parser: frames ADD/DELETE/unknown messages from a
// valid/ready beat stream and presents decoded fields on a one-entry registered output.
module itch_msg_parser_wide #(
    parameter int         BEAT_BYTES = 1,
    parameter logic [7:0] TYPE_ADD   = 8'h41,
    parameter logic [7:0] TYPE_DEL   = 8'h44,
    parameter int         CNT_W      = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [8*BEAT_BYTES-1:0] in_data,
    input  logic                    in_sop,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [7:0]              out_msg_type,
    output logic [7:0]              out_stock_id,
    output logic [31:0]             out_order_id,
    output logic [31:0]             out_price,
    output logic [31:0]             out_quantity,
    output logic                    out_err,
    output logic [CNT_W-1:0]        msg_count,
    output logic [CNT_W-1:0]        err_count,
    output logic [CNT_W-1:0]        drop_count
);

    localparam logic [4:0] N_ADD = 5'((16 + BEAT_BYTES - 1) / BEAT_BYTES);
    localparam logic [4:0] N_DEL = 5'((6 + BEAT_BYTES - 1) / BEAT_BYTES);

    typedef enum logic {ST_IDLE, ST_COLLECT} state_t;

    state_t           state_q, state_d;
    logic [4:0]       beat_cnt_q, beat_cnt_d;
    logic [4:0]       need_q, need_d;
    logic [15:0][7:0] buf_q, buf_d;
    logic             valid_q, valid_d;
    logic [7:0]       type_q, type_d;
    logic [7:0]       stock_q, stock_d;
    logic [31:0]      order_q, order_d;
    logic [31:0]      price_q, price_d;
    logic [31:0]      qty_q, qty_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] msg_cnt_q, msg_cnt_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    logic             acc;
    logic             take;
    logic             done;
    logic             is_add;
    logic             is_del;
    logic [4:0]       need_new;
    logic [15:0][7:0] merged;
    int               base;
    int               idx;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // A slot is free when empty or being drained this cycle; all beats obey it.
    assign in_ready = !valid_q || out_ready;

    always_comb begin
        acc        = in_valid && in_ready;
        take       = valid_q && out_ready;
        done       = 1'b0;
        base       = 0;
        idx        = 0;
        merged     = buf_q;
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        need_d     = need_q;
        buf_d      = buf_q;
        valid_d    = valid_q;
        type_d     = type_q;
        stock_d    = stock_q;
        order_d    = order_q;
        price_d    = price_q;
        qty_d      = qty_q;
        err_d      = err_q;
        msg_cnt_d  = msg_cnt_q;
        err_cnt_d  = err_cnt_q;
        drop_cnt_d = drop_cnt_q;

        // Overlay the current beat onto the capture buffer; bytes past 16 are padding.
        if (acc) begin
            base = in_sop ? 0 : int'(beat_cnt_q) * BEAT_BYTES;
            for (int k = 0; k < BEAT_BYTES; k++) begin
                idx = base + k;
                if (idx < 16) merged[idx[3:0]] = in_data[8*k +: 8];
            end
        end

        need_new = (in_data[7:0] == TYPE_DEL) ? N_DEL : N_ADD;
        is_add   = (merged[0] == TYPE_ADD);
        is_del   = (merged[0] == TYPE_DEL);

        if (acc) begin
            if (in_sop) begin
                if (state_q == ST_COLLECT) drop_cnt_d = sat_inc(drop_cnt_q);
                buf_d  = merged;
                need_d = need_new;
                if (need_new == 5'd1) begin
                    done       = 1'b1;
                    state_d    = ST_IDLE;
                    beat_cnt_d = 5'd0;
                end else begin
                    state_d    = ST_COLLECT;
                    beat_cnt_d = 5'd1;
                end
            end else if (state_q == ST_IDLE) begin
                drop_cnt_d = sat_inc(drop_cnt_q);
            end else begin
                buf_d = merged;
                if (beat_cnt_q == need_q - 5'd1) begin
                    done       = 1'b1;
                    state_d    = ST_IDLE;
                    beat_cnt_d = 5'd0;
                end else begin
                    beat_cnt_d = beat_cnt_q + 5'd1;
                end
            end
        end

        // Loading wins over draining so completion and handshake can share a cycle.
        if (done) begin
            valid_d   = 1'b1;
            type_d    = merged[0];
            stock_d   = merged[1];
            order_d   = {merged[2], merged[3], merged[4], merged[5]};
            price_d   = is_add ? {merged[6], merged[7], merged[8], merged[9]} : 32'd0;
            qty_d     = is_add ? {merged[10], merged[11], merged[12], merged[13]} : 32'd0;
            err_d     = !is_add && !is_del;
            msg_cnt_d = sat_inc(msg_cnt_q);
            if (!is_add && !is_del) err_cnt_d = sat_inc(err_cnt_q);
        end else if (take) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            beat_cnt_q <= 5'd0;
            need_q     <= 5'd0;
            valid_q    <= 1'b0;
            type_q     <= 8'd0;
            stock_q    <= 8'd0;
            order_q    <= 32'd0;
            price_q    <= 32'd0;
            qty_q      <= 32'd0;
            err_q      <= 1'b0;
            msg_cnt_q  <= '0;
            err_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            need_q     <= need_d;
            valid_q    <= valid_d;
            type_q     <= type_d;
            stock_q    <= stock_d;
            order_q    <= order_d;
            price_q    <= price_d;
            qty_q      <= qty_d;
            err_q      <= err_d;
            msg_cnt_q  <= msg_cnt_d;
            err_cnt_q  <= err_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Capture buffer is pure data; stale contents are never read before being overwritten.
    always_ff @(posedge clk) begin
        buf_q <= buf_d;
    end

    assign out_valid    = valid_q;
    assign out_msg_type = type_q;
    assign out_stock_id = stock_q;
    assign out_order_id = order_q;
    assign out_price    = price_q;
    assign out_quantity = qty_q;
    assign out_err      = err_q;
    assign msg_count    = msg_cnt_q;
    assign err_count    = err_cnt_q;
    assign drop_count   = drop_cnt_q;

endmodule

// File: tb/tb_itch_msg_parser_wide.sv
// Directed bench for itch_msg_parser_wide at 1-, 4- and 8-byte beat widths.
module tb_itch_msg_parser_wide;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // ---- DUT with 1-byte beats
    logic u1_in_valid = 0, u1_in_ready, u1_in_sop = 0, u1_out_valid, u1_out_ready = 1, u1_out_err;
    logic [7:0]  u1_in_data = 0, u1_type, u1_stock;
    logic [31:0] u1_order, u1_price, u1_qty;
    logic [15:0] u1_msg, u1_errc, u1_drop;

    itch_msg_parser_wide #(.BEAT_BYTES(1)) u1 (
        .clk(clk), .reset(reset), .in_valid(u1_in_valid), .in_ready(u1_in_ready),
        .in_data(u1_in_data), .in_sop(u1_in_sop), .out_valid(u1_out_valid),
        .out_ready(u1_out_ready), .out_msg_type(u1_type), .out_stock_id(u1_stock),
        .out_order_id(u1_order), .out_price(u1_price), .out_quantity(u1_qty),
        .out_err(u1_out_err), .msg_count(u1_msg), .err_count(u1_errc), .drop_count(u1_drop));

    // ---- DUT with 4-byte beats
    logic u4_in_valid = 0, u4_in_ready, u4_in_sop = 0, u4_out_valid, u4_out_ready = 1, u4_out_err;
    logic [31:0] u4_in_data = 0;
    logic [7:0]  u4_type, u4_stock;
    logic [31:0] u4_order, u4_price, u4_qty;
    logic [15:0] u4_msg, u4_errc, u4_drop;

    itch_msg_parser_wide #(.BEAT_BYTES(4)) u4 (
        .clk(clk), .reset(reset), .in_valid(u4_in_valid), .in_ready(u4_in_ready),
        .in_data(u4_in_data), .in_sop(u4_in_sop), .out_valid(u4_out_valid),
        .out_ready(u4_out_ready), .out_msg_type(u4_type), .out_stock_id(u4_stock),
        .out_order_id(u4_order), .out_price(u4_price), .out_quantity(u4_qty),
        .out_err(u4_out_err), .msg_count(u4_msg), .err_count(u4_errc), .drop_count(u4_drop));

    // ---- DUT with 8-byte beats (DELETE fits in one beat)
    logic u8_in_valid = 0, u8_in_ready, u8_in_sop = 0, u8_out_valid, u8_out_ready = 1, u8_out_err;
    logic [63:0] u8_in_data = 0;
    logic [7:0]  u8_type, u8_stock;
    logic [31:0] u8_order, u8_price, u8_qty;
    logic [15:0] u8_msg, u8_errc, u8_drop;

    itch_msg_parser_wide #(.BEAT_BYTES(8)) u8 (
        .clk(clk), .reset(reset), .in_valid(u8_in_valid), .in_ready(u8_in_ready),
        .in_data(u8_in_data), .in_sop(u8_in_sop), .out_valid(u8_out_valid),
        .out_ready(u8_out_ready), .out_msg_type(u8_type), .out_stock_id(u8_stock),
        .out_order_id(u8_order), .out_price(u8_price), .out_quantity(u8_qty),
        .out_err(u8_out_err), .msg_count(u8_msg), .err_count(u8_errc), .drop_count(u8_drop));

    typedef struct {
        logic [127:0] raw;   // byte 0 in the top byte
        int           len;
        logic [7:0]   typ;
        logic [7:0]   stock;
        logic [31:0]  order;
        logic [31:0]  price;
        logic [31:0]  qty;
        logic         err;
    } vec_t;

    vec_t tbl[4];

    function automatic logic [7:0] byte_of(input logic [127:0] raw, input int i);
        return raw[127-8*i -: 8];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Byte-serial send on u1; reports whether out_valid showed up before the last byte.
    task automatic send1(input logic [127:0] raw, input int len, output logic early);
        early = 1'b0;
        for (int i = 0; i < len; i++) begin
            u1_in_valid = 1'b1;
            u1_in_sop   = (i == 0);
            u1_in_data  = byte_of(raw, i);
            step();
            if (i < len - 1 && u1_out_valid) early = 1'b1;
        end
        u1_in_valid = 1'b0;
        u1_in_sop   = 1'b0;
    endtask

    task automatic send4(input logic [127:0] raw, input int len);
        for (int j = 0; j < (len + 3) / 4; j++) begin
            for (int k = 0; k < 4; k++) u4_in_data[8*k +: 8] = byte_of(raw, 4*j + k);
            u4_in_valid = 1'b1;
            u4_in_sop   = (j == 0);
            step();
        end
        u4_in_valid = 1'b0;
        u4_in_sop   = 1'b0;
    endtask

    function automatic logic [63:0] pack8(input logic [127:0] raw);
        logic [63:0] d;
        for (int k = 0; k < 8; k++) d[8*k +: 8] = byte_of(raw, k);
        return d;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic early;
        logic stall_bad;
        logic [127:0] add3;

        tbl[0] = '{128'h41_07_00000123_00002710_00000064_0000, 16, 8'h41, 8'h07, 32'h123, 32'd10000, 32'd100, 1'b0};
        tbl[1] = '{128'h44_07_00000123_0000_0000_0000_0000_0000, 6, 8'h44, 8'h07, 32'h123, 32'd0, 32'd0, 1'b0};
        tbl[2] = '{128'h5A_09_AABBCCDD_11223344_55667788_9900, 16, 8'h5A, 8'h09, 32'hAABBCCDD, 32'd0, 32'd0, 1'b1};
        tbl[3] = '{128'h41_22_DEADBEEF_00000001_FFFFFFFF_0000, 16, 8'h41, 8'h22, 32'hDEADBEEF, 32'h1, 32'hFFFFFFFF, 1'b0};

        // ---- reset state
        step(); step();
        reset = 1'b0;
        step();
        chk("rst_out_valid", 32'(u1_out_valid), 32'd0);
        chk("rst_in_ready",  32'(u1_in_ready),  32'd1);
        chk("rst_msg_count", 32'(u1_msg),       32'd0);
        chk("rst_order",     u1_order,          32'd0);

        // ---- back-to-back table on the 1-byte DUT
        for (int v = 0; v < 4; v++) begin
            send1(tbl[v].raw, tbl[v].len, early);
            chk($sformatf("v%0d_no_early", v), 32'(early),        32'd0);
            chk($sformatf("v%0d_valid", v),    32'(u1_out_valid), 32'd1);
            chk($sformatf("v%0d_type", v),     32'(u1_type),      32'(tbl[v].typ));
            chk($sformatf("v%0d_stock", v),    32'(u1_stock),     32'(tbl[v].stock));
            chk($sformatf("v%0d_order", v),    u1_order,          tbl[v].order);
            chk($sformatf("v%0d_price", v),    u1_price,          tbl[v].price);
            chk($sformatf("v%0d_qty", v),      u1_qty,            tbl[v].qty);
            chk($sformatf("v%0d_err", v),      32'(u1_out_err),   32'(tbl[v].err));
        end
        chk("tbl_msg_count",  32'(u1_msg),  32'd4);
        chk("tbl_err_count",  32'(u1_errc), 32'd1);
        chk("tbl_drop_count", 32'(u1_drop), 32'd0);
        step();
        chk("tbl_valid_clears", 32'(u1_out_valid), 32'd0);

        // ---- new sop on byte 5 of an ADD drops the partial
        add3 = 128'h41_33_00000042_00000005_00000006_0000;
        send1(tbl[0].raw, 5, early);
        chk("part_no_valid", 32'(u1_out_valid), 32'd0);
        send1(add3, 16, early);
        chk("part_no_early", 32'(early),        32'd0);
        chk("part_valid",    32'(u1_out_valid), 32'd1);
        chk("part_order",    u1_order,          32'h42);
        chk("part_price",    u1_price,          32'd5);
        chk("part_qty",      u1_qty,            32'd6);
        chk("part_drop",     32'(u1_drop),      32'd1);
        chk("part_msg",      32'(u1_msg),       32'd5);
        // stray non-sop beat while idle
        u1_in_valid = 1'b1; u1_in_sop = 1'b0; u1_in_data = 8'h77;
        step();
        u1_in_valid = 1'b0;
        chk("stray_drop",  32'(u1_drop),      32'd2);
        chk("stray_valid", 32'(u1_out_valid), 32'd0);
        chk("stray_msg",   32'(u1_msg),       32'd5);

        // ---- 4-byte beats: unknown type then ADD and DELETE with junk padding
        send4(128'h5A_01_11223344_55667788_99AABBCC_DDEE, 16);
        chk("b4_unk_valid", 32'(u4_out_valid), 32'd1);
        chk("b4_unk_err",   32'(u4_out_err),   32'd1);
        chk("b4_unk_type",  32'(u4_type),      32'h5A);
        chk("b4_unk_order", u4_order,          32'h11223344);
        chk("b4_unk_price", u4_price,          32'd0);
        chk("b4_unk_errc",  32'(u4_errc),      32'd1);
        chk("b4_unk_msgc",  32'(u4_msg),       32'd1);
        send4(128'h41_02_00000010_00000020_00000030_0000, 16);
        chk("b4_add_valid", 32'(u4_out_valid), 32'd1);
        chk("b4_add_err",   32'(u4_out_err),   32'd0);
        chk("b4_add_stock", 32'(u4_stock),     32'h02);
        chk("b4_add_order", u4_order,          32'h10);
        chk("b4_add_price", u4_price,          32'h20);
        chk("b4_add_qty",   u4_qty,            32'h30);
        chk("b4_add_msgc",  32'(u4_msg),       32'd2);
        chk("b4_add_errc",  32'(u4_errc),      32'd1);
        send4(128'h44_03_12345678_EEEE_0000_0000_0000_0000, 6);
        chk("b4_del_valid", 32'(u4_out_valid), 32'd1);
        chk("b4_del_order", u4_order,          32'h12345678);
        chk("b4_del_price", u4_price,          32'd0);
        chk("b4_del_qty",   u4_qty,            32'd0);
        chk("b4_del_msgc",  32'(u4_msg),       32'd3);

        // ---- 8-byte beats: stall with a second message waiting, then back-to-back
        u8_out_ready = 1'b0;
        u8_in_valid = 1'b1; u8_in_sop = 1'b1;
        u8_in_data = pack8(128'h44_01_0A0B0C0D_EEEE_0000_0000_0000_0000);
        step();
        chk("b8_a_valid", 32'(u8_out_valid), 32'd1);
        chk("b8_a_order", u8_order,          32'h0A0B0C0D);
        u8_in_data = pack8(128'h44_02_01020304_0000_0000_0000_0000_0000);
        stall_bad = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (u8_in_ready !== 1'b0 || u8_out_valid !== 1'b1 || u8_order !== 32'h0A0B0C0D
                || u8_stock !== 8'h01) stall_bad = 1'b1;
            step();
        end
        chk("b8_stall_stable", 32'(stall_bad),    32'd0);
        chk("b8_stall_ready",  32'(u8_in_ready),  32'd0);
        chk("b8_stall_msgc",   32'(u8_msg),       32'd1);
        u8_out_ready = 1'b1;
        #1;
        chk("b8_release_ready", 32'(u8_in_ready), 32'd1);
        step();
        u8_in_valid = 1'b0; u8_in_sop = 1'b0;
        chk("b8_b2b_valid", 32'(u8_out_valid), 32'd1);
        chk("b8_b_order",   u8_order,          32'h01020304);
        chk("b8_b_stock",   32'(u8_stock),     32'h02);
        chk("b8_b_msgc",    32'(u8_msg),       32'd2);
        step();
        chk("b8_drain", 32'(u8_out_valid), 32'd0);

        // ---- reset on byte 9 of an ADD on the 1-byte DUT
        send1(tbl[3].raw, 9, early);
        reset = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(u1_out_valid), 32'd0);
        chk("mid_rst_msgc",  32'(u1_msg),       32'd0);
        chk("mid_rst_drop",  32'(u1_drop),      32'd0);
        chk("mid_rst_errc",  32'(u1_errc),      32'd0);
        chk("mid_rst_type",  32'(u1_type),      32'd0);
        step();
        reset = 1'b0;
        step(); step();
        chk("post_rst_quiet", 32'(u1_out_valid), 32'd0);
        send1(128'h44_09_CAFEF00D_0000_0000_0000_0000_0000, 6, early);
        chk("post_rst_valid", 32'(u1_out_valid), 32'd1);
        chk("post_rst_type",  32'(u1_type),      32'h44);
        chk("post_rst_order", u1_order,          32'hCAFEF00D);
        chk("post_rst_msgc",  32'(u1_msg),       32'd1);
        chk("post_rst_drop",  32'(u1_drop),      32'd0);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
